// File: rtl/pixel_mem_writer.sv
// pixel_mem_writer
//   Write side of the banked image memory. A processed-pixel stream is stored
//   into five byte-wide banks using the same linear map as the image read path:
//     bank 0 : 0              .. BANK_DEPTH-1
//     bank 1 : BANK_DEPTH     .. 2*BANK_DEPTH-1
//     bank 2 : 2*BANK_DEPTH   .. 3*BANK_DEPTH-1
//     bank 3 : 3*BANK_DEPTH   .. 4*BANK_DEPTH-1
//     bank 4 : 4*BANK_DEPTH   .. TOTAL_PIXELS-1   (LAST_DEPTH entries)
//   A three-state FSM (IDLE / WRITE / DONE) sequences one frame. A registered
//   read-back port serves the VGA/export path.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous reset, active-low
//   start      : begin a frame (honoured in IDLE and DONE)
//   abort      : cancel the frame, back to IDLE next cycle
//   pix_valid  : pixel present on pix_data
//   pix_data   : pixel value
//   pix_ready  : writer accepts a pixel this cycle (WRITE only)
//   busy       : FSM in WRITE
//   done       : frame complete, held until the next start
//   wr_addr    : linear address of the next pixel to be written
//   rd_addr    : read-back address
//   rd_data    : read-back pixel, zero-extended, one cycle latency
//
// Configuration
//   This build performs no file output; the synthesizable datapath is the
//   same regardless of PIXEL_DUMP_EN.

module pixel_mem_writer #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 20,
  parameter int BANK_DEPTH   = 65000,
  parameter int LAST_DEPTH   = 47200,
  parameter int TOTAL_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic              pix_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  localparam int OFF_W  = $clog2(BANK_DEPTH);
  localparam int LAST_W = $clog2(LAST_DEPTH);

  localparam logic [ADDR_W-1:0] BASE1  = ADDR_W'(BANK_DEPTH);
  localparam logic [ADDR_W-1:0] BASE2  = ADDR_W'(2 * BANK_DEPTH);
  localparam logic [ADDR_W-1:0] BASE3  = ADDR_W'(3 * BANK_DEPTH);
  localparam logic [ADDR_W-1:0] BASE4  = ADDR_W'(4 * BANK_DEPTH);
  localparam logic [ADDR_W-1:0] TOTAL  = ADDR_W'(TOTAL_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(TOTAL_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [OFF_W-1:0]  OFF_END = OFF_W'(BANK_DEPTH - 1);
  localparam logic [OFF_W-1:0]  ONE_O   = OFF_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]       bank_sel;
  logic [OFF_W-1:0] offset;

  logic [DATA_W-1:0] bank0 [BANK_DEPTH];
  logic [DATA_W-1:0] bank1 [BANK_DEPTH];
  logic [DATA_W-1:0] bank2 [BANK_DEPTH];
  logic [DATA_W-1:0] bank3 [BANK_DEPTH];
  logic [DATA_W-1:0] bank4 [LAST_DEPTH];

  logic xfer;
  logic clr;

  // abort always beats both a pending transfer and a start request
  assign xfer = (state_q == S_WRITE) && pix_valid && !abort;
  assign clr  = (state_q != S_WRITE) && start && !abort;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pix_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!abort && start) state_d = S_WRITE;
      end
      S_WRITE: begin
        pix_ready = 1'b1;
        busy      = 1'b1;
        if (abort)                          state_d = S_IDLE;
        else if (pix_valid && wr_addr == LAST_A) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_WRITE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- address counters
  // wr_addr is kept in step with bank_sel/offset rather than recomputed from
  // them. On the final transfer of a frame the counters hold, so wr_addr
  // reads TOTAL_PIXELS-1 while in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_sel <= 3'd0;
      offset   <= '0;
      wr_addr  <= '0;
    end else if (clr) begin
      bank_sel <= 3'd0;
      offset   <= '0;
      wr_addr  <= '0;
    end else if (xfer && wr_addr != LAST_A) begin
      wr_addr <= wr_addr + ONE_A;
      if (offset == OFF_END && bank_sel != 3'd4) begin
        offset   <= '0;
        bank_sel <= bank_sel + 3'd1;
      end else begin
        offset <= offset + ONE_O;
      end
    end
  end

  // ---------------------------------------------------------------- bank write
  always_ff @(posedge clk) begin
    if (xfer) begin
      case (bank_sel)
        3'd0:    bank0[offset] <= pix_data;
        3'd1:    bank1[offset] <= pix_data;
        3'd2:    bank2[offset] <= pix_data;
        3'd3:    bank3[offset] <= pix_data;
        3'd4:    bank4[offset[LAST_W-1:0]] <= pix_data;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- read-back decode
  logic [2:0]        rd_sel;
  logic              rd_hit;
  logic [OFF_W-1:0]  rd_off;
  logic [DATA_W-1:0] rd_byte;

  always_comb begin
    rd_sel = 3'd0;
    rd_hit = 1'b1;
    rd_off = '0;
    if (rd_addr < BASE1) begin
      rd_sel = 3'd0;
      rd_off = OFF_W'(rd_addr);
    end else if (rd_addr < BASE2) begin
      rd_sel = 3'd1;
      rd_off = OFF_W'(rd_addr - BASE1);
    end else if (rd_addr < BASE3) begin
      rd_sel = 3'd2;
      rd_off = OFF_W'(rd_addr - BASE2);
    end else if (rd_addr < BASE4) begin
      rd_sel = 3'd3;
      rd_off = OFF_W'(rd_addr - BASE3);
    end else if (rd_addr < TOTAL) begin
      rd_sel = 3'd4;
      rd_off = OFF_W'(rd_addr - BASE4);
    end else begin
      rd_hit = 1'b0;
    end
  end

  always_comb begin
    rd_byte = '0;
    if (rd_hit) begin
      case (rd_sel)
        3'd0:    rd_byte = bank0[rd_off];
        3'd1:    rd_byte = bank1[rd_off];
        3'd2:    rd_byte = bank2[rd_off];
        3'd3:    rd_byte = bank3[rd_off];
        3'd4:    rd_byte = bank4[rd_off[LAST_W-1:0]];
        default: rd_byte = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------- read-back register
  // The array is sampled before this edge's bank write lands, so a same-address
  // read and write returns the old pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data <= '0;
    else      rd_data <= {{(32-DATA_W){1'b0}}, rd_byte};
  end

endmodule

// File: tb/tb_pixel_mem_writer.sv
// Bench for pixel_mem_writer with a reduced frame (5 banks: 20,20,20,20,12).
// Read-back expectations go through a scoreboard queue; a monitor pops them
// one cycle after each read request.

module tb_pixel_mem_writer;

  localparam int DW = 8;
  localparam int AW = 10;
  localparam int BD = 20;
  localparam int LD = 12;
  localparam int TP = 4 * BD + LD;  // 92

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;

  always #5 clk = ~clk;

  pixel_mem_writer #(
    .DATA_W(DW), .ADDR_W(AW), .BANK_DEPTH(BD), .LAST_DEPTH(LD), .TOTAL_PIXELS(TP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .busy(busy), .done(done), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard
  logic [31:0] exp_q[$];
  int          addr_q[$];
  logic        rd_req = 1'b0;
  logic        req_d  = 1'b0;

  always @(posedge clk) req_d <= rd_req;

  always @(negedge clk) begin
    if (req_d) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h with no expected entry", rd_data);
      end else begin
        logic [31:0] e;
        int a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("rd_data@%0d", a), rd_data, e);
      end
    end
  end

  // accepted-transfer counter
  int   xfer_cnt = 0;
  logic xfer_clr = 1'b0;
  always @(posedge clk) begin
    if (xfer_clr) xfer_cnt <= 0;
    else if (pix_valid && pix_ready && !abort) xfer_cnt <= xfer_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rd(input int a, input logic [7:0] v);
    rd_addr = AW'(a);
    rd_req  = 1'b1;
    exp_q.push_back({24'b0, v});
    addr_q.push_back(a);
  endtask

  task automatic rd(input int a, input logic [7:0] v);
    issue_rd(a, v);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic start_frame();
    start    = 1'b1;
    xfer_clr = 1'b1;
    tick();
    start    = 1'b0;
    xfer_clr = 1'b0;
  endtask

  function automatic logic [7:0] f1(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] f2(input int i);
    if (i == 39) return 8'hAA;
    if (i == 40) return 8'h55;
    return 8'(i + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i, c;
    logic v;
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pix_valid = 1'b0; pix_data = '0; rd_addr = '0;
    #12;
    check("rst_pix_ready", 32'(pix_ready), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_done",      32'(done), 0);
    check("rst_wr_addr",   32'(wr_addr), 0);
    check("rst_rd_data",   rd_data, 0);
    rst = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 0);

    // frame 1: continuous stream
    start_frame();
    check("f1_busy",      32'(busy), 1);
    check("f1_pix_ready", 32'(pix_ready), 1);
    check("f1_wr_addr0",  32'(wr_addr), 0);
    check("f1_done0",     32'(done), 0);
    for (int k = 0; k < TP; k++) begin
      pix_valid = 1'b1;
      pix_data  = f1(k);
      if (k == TP - 1) check("f1_done_before_last", 32'(done), 0);
      tick();
    end
    pix_valid = 1'b0;
    check("f1_done",      32'(done), 1);
    check("f1_done_busy", 32'(busy), 0);
    check("f1_done_rdy",  32'(pix_ready), 0);
    rd(19, f1(19));   // 8'h49
    rd(20, f1(20));   // 8'h4E
    rd(39, f1(39));   // 8'h7D
    rd(40, f1(40));   // 8'h72
    rd(91, f1(91));   // 8'h01
    rd(0,  f1(0));    // 8'h5A
    rd(92, 8'h00);
    rd(1023, 8'h00);

    // start with abort in DONE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start_done", 32'(done), 0);
    check("abort_beats_start_busy", 32'(busy), 0);

    // frame 2: gapped stream, bank-boundary markers at 39/40
    start_frame();
    i = 0; c = 0;
    while (i < TP && c < 2000) begin
      v = ((c * 7) % 5) < 3;
      pix_valid = v;
      pix_data  = v ? f2(i) : 8'hFF;
      check("f2_wr_addr_seq", 32'(wr_addr), 32'(i));
      check("f2_done_early",  32'(done), 0);
      tick();
      if (v) i++;
      c++;
    end
    pix_valid = 1'b0;
    if (i < TP) begin
      n_checks++; n_fail++;
      $display("FAIL f2_timeout: wrote %0d pixels, expected %0d", i, TP);
    end
    check("f2_done",     32'(done), 1);
    check("f2_xfer_cnt", 32'(xfer_cnt), 32'(TP));
    rd(38, f2(38));   // 8'h27
    rd(39, 8'hAA);
    rd(40, 8'h55);
    rd(41, f2(41));   // 8'h2A

    // frame 3: start ignored in WRITE, read-first at 5, abort at 10
    start_frame();
    for (int k = 0; k < 10; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(8'hC0 + k);
      if (k == 3) start = 1'b1;
      if (k == 5) issue_rd(5, 8'h06);   // old frame-2 value
      if (k == 6) issue_rd(5, 8'hC5);   // value written the cycle before
      check("f3_wr_addr_seq", 32'(wr_addr), 32'(k));
      tick();
      start  = 1'b0;
      rd_req = 1'b0;
    end
    pix_valid = 1'b1; pix_data = 8'hEE; abort = 1'b1;
    tick();
    abort = 1'b0; pix_valid = 1'b0;
    check("abort_busy",      32'(busy), 0);
    check("abort_pix_ready", 32'(pix_ready), 0);
    check("abort_done",      32'(done), 0);
    check("abort_wr_addr",   32'(wr_addr), 10);
    tick();
    check("abort_wr_addr_hold", 32'(wr_addr), 10);
    rd(10, 8'h0B);
    rd(9,  8'hC9);
    rd(5,  8'hC5);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort_start_busy", 32'(busy), 0);
    check("idle_abort_start_addr", 32'(wr_addr), 10);

    // frame 4: asynchronous reset mid-frame at address 25
    rd_addr = AW'(20);
    start_frame();
    check("f4_wr_addr0", 32'(wr_addr), 0);
    for (int k = 0; k < 25; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(8'h80 + k);
      tick();
    end
    check("f4_wr_addr25",   32'(wr_addr), 25);
    check("f4_rd_data_pre", rd_data, 32'h94);
    #2 rst = 1'b0;
    #1;
    check("arst_pix_ready", 32'(pix_ready), 0);
    check("arst_busy",      32'(busy), 0);
    check("arst_done",      32'(done), 0);
    check("arst_wr_addr",   32'(wr_addr), 0);
    check("arst_rd_data",   rd_data, 0);
    #2 rst = 1'b1;
    pix_valid = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    rd(0,  8'h80);
    rd(24, 8'h98);
    rd(25, 8'h1A);
    rd(40, 8'h55);

    repeat (3) tick();
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
